// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer.
// Holds the sequencer state encoding, the fixed three-program schedule
// (entry and done addresses) and the pointer-advance helper.
package program_sequencer_pkg;

    localparam int ADDR_W    = 10;
    localparam int CNT_W     = 16;
    localparam int NUM_PROGS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Plain vector constants for the FSM register, tied to the enum encoding.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [ADDR_W-1:0] PROG_START [NUM_PROGS] = '{10'd0,   10'd400, 10'd450};
    localparam logic [ADDR_W-1:0] PROG_END   [NUM_PROGS] = '{10'd400, 10'd450, 10'd800};

    // Round-robin through the schedule: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_prog(input logic [1:0] p);
        return (p >= 2'(NUM_PROGS - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/program_sequencer_prog_table.sv
// Program schedule lookup.
// Ports:
//   sel        in  2  program index
//   start_addr out D  entry address of the selected program
//   end_addr   out D  done address of the selected program
// Out-of-range indices fall back to program 0.
module prog_table
    import program_sequencer_pkg::*;
#(
    parameter int             D        = ADDR_W,
    parameter logic [D-1:0]   P0_START = PROG_START[0],
    parameter logic [D-1:0]   P0_END   = PROG_END[0],
    parameter logic [D-1:0]   P1_START = PROG_START[1],
    parameter logic [D-1:0]   P1_END   = PROG_END[1],
    parameter logic [D-1:0]   P2_START = PROG_START[2],
    parameter logic [D-1:0]   P2_END   = PROG_END[2]
) (
    input  logic [1:0]   sel,
    output logic [D-1:0] start_addr,
    output logic [D-1:0] end_addr
);

    always_comb begin
        start_addr = P0_START;
        end_addr   = P0_END;
        case (sel)
            2'd1: begin
                start_addr = P1_START;
                end_addr   = P1_END;
            end
            2'd2: begin
                start_addr = P2_START;
                end_addr   = P2_END;
            end
            default: begin
                start_addr = P0_START;
                end_addr   = P0_END;
            end
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Run-control for the 9-bit single-cycle CPU.
// Each accepted start edge loads the pc with the entry address of the next
// program in a fixed three-program schedule, then enables the datapath until
// the pc equals that program's done address or the cycle watchdog expires.
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   start        in   1   run request level; only 0->1 edges act
//   pc           in   D   current program counter
//   pc_load      out  1   one-cycle strobe, pc takes pc_target next edge
//   pc_target    out  D   entry address of the selected program
//   run          out  1   pc advance / write enable
//   done         out  1   program finished, held until the next launch
//   timeout      out  1   with done: watchdog ended the run
//   prog_sel     out  2   program index of current/last run
//   cycle_count  out  CW  RUN cycles of current/last run
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int             D        = ADDR_W,
    parameter logic [D-1:0]   P0_START = PROG_START[0],
    parameter logic [D-1:0]   P0_END   = PROG_END[0],
    parameter logic [D-1:0]   P1_START = PROG_START[1],
    parameter logic [D-1:0]   P1_END   = PROG_END[1],
    parameter logic [D-1:0]   P2_START = PROG_START[2],
    parameter logic [D-1:0]   P2_END   = PROG_END[2],
    parameter int             CW       = CNT_W,
    parameter int             MAX_CYC  = 65535
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  pc,
    output logic          pc_load,
    output logic [D-1:0]  pc_target,
    output logic          run,
    output logic          done,
    output logic          timeout,
    output logic [1:0]    prog_sel,
    output logic [CW-1:0] cycle_count
);

    localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYC - 1);

    logic [1:0]   state;
    logic [1:0]   ptr;
    logic         start_q;
    logic         start_edge;
    logic         can_launch;
    logic         end_hit;
    logic         wd_hit;
    logic [D-1:0] end_addr;

    prog_table #(
        .D        (D),
        .P0_START (P0_START),
        .P0_END   (P0_END),
        .P1_START (P1_START),
        .P1_END   (P1_END),
        .P2_START (P2_START),
        .P2_END   (P2_END)
    ) u_table (
        .sel        (prog_sel),
        .start_addr (pc_target),
        .end_addr   (end_addr)
    );

    assign start_edge = start & ~start_q;
    // Edges arriving in LOAD or RUN are dropped, not queued.
    assign can_launch = (state == ST_IDLE) || (state == ST_DONE);
    assign end_hit    = (pc == end_addr);
    assign wd_hit     = (cycle_count == WD_LAST);

    assign pc_load = (state == ST_LOAD);
    assign run     = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= 2'd0;
            start_q     <= 1'b0;
            prog_sel    <= 2'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            start_q <= start;
            case (state)
                ST_LOAD: begin
                    done        <= 1'b0;
                    timeout     <= 1'b0;
                    cycle_count <= '0;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    // End match wins over the watchdog in the same cycle;
                    // the terminating cycle is not counted.
                    if (end_hit) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (wd_hit) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    if (can_launch && start_edge) begin
                        state    <= ST_LOAD;
                        prog_sel <= ptr;
                        ptr      <= next_prog(ptr);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus pushes expected pc_load
// targets and run completions; a negedge monitor pops and compares them.
// dut0 uses the default watchdog with a modelled pc; dut1 uses MAX_CYC=20
// with a pc driven directly by the bench.
module tb_program_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, pc_load0, run0, done0, timeout0;
    logic [9:0] pc0, pc_target0;
    logic [1:0] prog_sel0;
    logic [15:0] cycle_count0;

    logic       rst1, start1, pc_load1, run1, done1, timeout1;
    logic [9:0] pc1, pc_target1;
    logic [1:0] prog_sel1;
    logic [15:0] cycle_count1;

    program_sequencer dut0 (
        .clk(clk), .reset(rst0), .start(start0), .pc(pc0),
        .pc_load(pc_load0), .pc_target(pc_target0), .run(run0),
        .done(done0), .timeout(timeout0), .prog_sel(prog_sel0),
        .cycle_count(cycle_count0)
    );

    program_sequencer #(.MAX_CYC(20)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .pc(pc1),
        .pc_load(pc_load1), .pc_target(pc_target1), .run(run1),
        .done(done1), .timeout(timeout1), .prog_sel(prog_sel1),
        .cycle_count(cycle_count1)
    );

    // pc behaviour for dut0: load on pc_load, advance while run.
    always @(posedge clk or negedge rst0) begin
        if (!rst0)         pc0 <= 10'd0;
        else if (pc_load0) pc0 <= pc_target0;
        else if (run0)     pc0 <= pc0 + 10'd1;
    end

    typedef struct packed {
        logic [1:0]  sel;
        logic        to;
        logic [15:0] cc;
    } done_t;

    done_t exp_done0[$];
    done_t exp_done1[$];
    int    exp_tgt0[$];
    int    exp_tgt1[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_run(input int d, input int tgt, input int sel,
                            input int to, input int cc, input bit finishes);
        done_t e;
        e.sel = 2'(sel);
        e.to  = 1'(to);
        e.cc  = 16'(cc);
        if (d == 0) begin
            exp_tgt0.push_back(tgt);
            if (finishes) exp_done0.push_back(e);
        end else begin
            exp_tgt1.push_back(tgt);
            if (finishes) exp_done1.push_back(e);
        end
    endtask

    // Monitor: pop expectations whenever a DUT presents pc_load or a new done.
    logic  done0_d = 1'b0;
    logic  done1_d = 1'b0;
    done_t m0, m1;
    always @(negedge clk) begin
        if (pc_load0) begin
            if (exp_tgt0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected pc_load target %0d expected none", pc_target0);
            end else chk("dut0 pc_target", int'(pc_target0), exp_tgt0.pop_front());
        end
        if (done0 && !done0_d) begin
            if (exp_done0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected done prog_sel %0d expected none", prog_sel0);
            end else begin
                m0 = exp_done0.pop_front();
                chk("dut0 done prog_sel", int'(prog_sel0), int'(m0.sel));
                chk("dut0 done timeout", int'(timeout0), int'(m0.to));
                chk("dut0 done cycle_count", int'(cycle_count0), int'(m0.cc));
                chk("dut0 done run", int'(run0), 0);
            end
        end
        if (pc_load1) begin
            if (exp_tgt1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected pc_load target %0d expected none", pc_target1);
            end else chk("dut1 pc_target", int'(pc_target1), exp_tgt1.pop_front());
        end
        if (done1 && !done1_d) begin
            if (exp_done1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected done prog_sel %0d expected none", prog_sel1);
            end else begin
                m1 = exp_done1.pop_front();
                chk("dut1 done prog_sel", int'(prog_sel1), int'(m1.sel));
                chk("dut1 done timeout", int'(timeout1), int'(m1.to));
                chk("dut1 done cycle_count", int'(cycle_count1), int'(m1.cc));
                chk("dut1 done run", int'(run1), 0);
            end
        end
        done0_d <= done0;
        done1_d <= done1;
    end

    function automatic logic sig(input int d, input int w);
        case ({d[0], w[1:0]})
            3'b000:  return run0;
            3'b001:  return done0;
            3'b010:  return run0 && (pc0 == 10'd800);
            3'b100:  return run1;
            3'b101:  return done1;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait on a DUT condition; an expired bound is a failed check.
    task automatic wait_for(input int d, input int w, input int lim, input string nm);
        int  k;
        bit  hit;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < lim) begin
            @(negedge clk);
            hit = sig(d, w);
            k++;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait %s not seen within %0d cycles", nm, lim);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int d);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        cyc(1);
        if (d == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        pc1 = 10'd5;
        cyc(3);
        // Reset state.
        chk("rst pc_load", int'(pc_load0), 0);
        chk("rst pc_target", int'(pc_target0), 0);
        chk("rst run", int'(run0), 0);
        chk("rst done", int'(done0), 0);
        chk("rst timeout", int'(timeout0), 0);
        chk("rst prog_sel", int'(prog_sel0), 0);
        chk("rst cycle_count", int'(cycle_count0), 0);
        rst0 = 1'b1; rst1 = 1'b1;
        cyc(1);

        // 1: first launch, latency and completion of program 0.
        push_run(0, 0, 0, 0, 400, 1'b1);
        start0 = 1'b1;
        cyc(1);
        chk("t1 pc_load after edge", int'(pc_load0), 1);
        chk("t1 run during load", int'(run0), 0);
        cyc(1);
        chk("t1 pc_load one cycle", int'(pc_load0), 0);
        chk("t1 run two after edge", int'(run0), 1);
        start0 = 1'b0;
        wait_for(0, 1, 500, "t1 done");
        cyc(2);

        // 2: schedule order 400, 450, then wrap to 0.
        push_run(0, 400, 1, 0, 50, 1'b1);
        pulse(0); wait_for(0, 0, 10, "t2a run"); wait_for(0, 1, 200, "t2a done"); cyc(2);
        push_run(0, 450, 2, 0, 350, 1'b1);
        pulse(0); wait_for(0, 0, 10, "t2b run"); wait_for(0, 1, 500, "t2b done"); cyc(2);
        push_run(0, 0, 0, 0, 400, 1'b1);
        pulse(0); wait_for(0, 0, 10, "t2c run"); wait_for(0, 1, 500, "t2c done"); cyc(2);

        // 4: start held high with a re-pulse mid-RUN gives a single run.
        push_run(0, 400, 1, 0, 50, 1'b1);
        start0 = 1'b1;
        wait_for(0, 0, 10, "t4 run");
        cyc(10);
        start0 = 1'b0;
        cyc(1);
        start0 = 1'b1;
        wait_for(0, 1, 200, "t4 done");
        cyc(5);
        chk("t4 done held", int'(done0), 1);
        chk("t4 no relaunch run", int'(run0), 0);
        start0 = 1'b0;
        cyc(2);

        // 6: start edge on the same edge as the end match is ignored.
        push_run(0, 450, 2, 0, 350, 1'b1);
        pulse(0);
        wait_for(0, 0, 10, "t6 run");
        wait_for(0, 2, 500, "t6 pc at end");
        start0 = 1'b1;
        cyc(1);
        chk("t6 done first", int'(done0), 1);
        cyc(5);
        chk("t6 still done", int'(done0), 1);
        chk("t6 no relaunch run", int'(run0), 0);
        chk("t6 prog_sel kept", int'(prog_sel0), 2);
        start0 = 1'b0;
        cyc(2);
        push_run(0, 0, 0, 0, 0, 1'b0);
        pulse(0);
        wait_for(0, 0, 10, "t6 relaunch run");
        cyc(30);

        // 5: asynchronous reset mid-RUN.
        #2 rst0 = 1'b0;
        #1;
        chk("t5 run cleared", int'(run0), 0);
        chk("t5 pc_load cleared", int'(pc_load0), 0);
        chk("t5 done cleared", int'(done0), 0);
        chk("t5 cycle_count cleared", int'(cycle_count0), 0);
        @(negedge clk);
        rst0 = 1'b1;
        cyc(2);
        push_run(0, 0, 0, 0, 400, 1'b1);
        pulse(0); wait_for(0, 0, 10, "t5 run"); wait_for(0, 1, 500, "t5 done"); cyc(2);

        // 3: watchdog on dut1 (MAX_CYC=20), pc stuck at 5.
        push_run(1, 0, 0, 1, 19, 1'b1);
        pulse(1); wait_for(1, 0, 10, "t3a run"); wait_for(1, 1, 100, "t3a done");
        cyc(2);
        // Same limit, but the end address shows up on the watchdog cycle.
        push_run(1, 400, 1, 0, 19, 1'b1);
        pulse(1);
        wait_for(1, 0, 10, "t3b run");
        for (int k = 0; k < 100 && !done1; k++) begin
            if (run1 && cycle_count1 == 16'd19) pc1 = 10'd450;
            @(negedge clk);
        end
        chk("t3b done", int'(done1), 1);
        pc1 = 10'd5;
        cyc(3);

        chk("dut0 targets drained", exp_tgt0.size(), 0);
        chk("dut0 runs drained", exp_done0.size(), 0);
        chk("dut1 targets drained", exp_tgt1.size(), 0);
        chk("dut1 runs drained", exp_done1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
